// File: rtl/watchdog_reset_gen_pkg.sv
// Shared watchdog constants: counter and field widths used by the reset generator.
package watchdog_reset_gen_pkg;
   localparam int GRACE_W = 16;
   localparam int PULSE_W = 8;
   localparam int CNT_W   = 16;
   localparam int EVCNT_W = 8;
   localparam logic [EVCNT_W-1:0] EVCNT_MAX = '1;
endpackage

// File: rtl/watchdog_reset_gen.sv
// Watchdog timeout escalation: warning interrupt, then a timed system reset request,
// then hold until the core drops its timeout.
module watchdog_reset_gen
   import watchdog_reset_gen_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               timeout,
   input  logic [GRACE_W-1:0] grace_cycles,
   input  logic [PULSE_W-1:0] pulse_len,
   input  logic               irq_ack,
   input  logic               cause_clear,
   output logic               irq,
   output logic               sys_reset_req,
   output logic               core_reset,
   output logic               cause,
   output logic [EVCNT_W-1:0] event_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WARN  = 2'd1;
   localparam logic [1:0] S_RESET = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]         state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic               timeout_prev, ev_start;
   logic               irq_nx, sys_nx, core_nx, cause_nx;
   logic [EVCNT_W-1:0] evc_nx;

   assign ev_start = timeout & ~timeout_prev;

   // State, shared counter and every output are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         timeout_prev  <= 1'b0;
         irq           <= 1'b0;
         sys_reset_req <= 1'b0;
         core_reset    <= 1'b0;
         cause         <= 1'b0;
         event_count   <= '0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         timeout_prev  <= timeout;
         irq           <= irq_nx;
         sys_reset_req <= sys_nx;
         core_reset    <= core_nx;
         cause         <= cause_nx;
         event_count   <= evc_nx;
      end
   end

   // One down-counter serves both the warning window and the reset pulse.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         S_IDLE: begin
            if (ev_start) begin
               state_nx = S_WARN;
               cnt_nx   = grace_cycles;
            end
         end
         S_WARN: begin
            if (irq_ack) begin
               state_nx = S_IDLE;
            end else if (cnt == '0) begin
               state_nx = S_RESET;
               cnt_nx   = CNT_W'(pulse_len);
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         S_RESET: begin
            if (cnt == '0) state_nx = S_HOLD;
            else           cnt_nx   = cnt - CNT_W'(1);
         end
         S_HOLD: begin
            if (!timeout) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs are the registered image of the state being entered.
   always_comb begin
      irq_nx   = (state_nx == S_WARN);
      sys_nx   = (state_nx == S_RESET);
      core_nx  = (state_nx == S_RESET) | ((state == S_WARN) & irq_ack);
      cause_nx = cause;
      evc_nx   = event_count;
      if (cause_clear) cause_nx = 1'b0;
      if ((state == S_IDLE) && ev_start) begin
         cause_nx = 1'b1;
         if (event_count != EVCNT_MAX) evc_nx = event_count + EVCNT_W'(1);
      end
   end

endmodule

// File: tb/tb_watchdog_reset_gen.sv
// Directed vector table plus hand sequences for saturation, long windows and reset abort.
module tb_watchdog_reset_gen;
   logic        clk = 1'b0;
   logic        reset, timeout, irq_ack, cause_clear;
   logic [15:0] grace_cycles;
   logic [7:0]  pulse_len;
   logic        irq, sys_reset_req, core_reset, cause;
   logic [7:0]  event_count;

   int n_cmp = 0;
   int n_bad = 0;

   watchdog_reset_gen dut (
      .clk(clk), .reset(reset), .timeout(timeout), .grace_cycles(grace_cycles),
      .pulse_len(pulse_len), .irq_ack(irq_ack), .cause_clear(cause_clear),
      .irq(irq), .sys_reset_req(sys_reset_req), .core_reset(core_reset),
      .cause(cause), .event_count(event_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, to;
      logic [15:0] gr;
      logic [7:0]  pl;
      logic        ack, clr;
      logic        e_irq, e_sys, e_core, e_cause;
      logic [7:0]  e_cnt;
   } vec_t;

   localparam int NV = 29;
   vec_t vecs [NV];

   task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic to, input logic [15:0] gr,
                       input logic [7:0] pl, input logic ack, input logic clr);
      reset = rst; timeout = to; grace_cycles = gr; pulse_len = pl;
      irq_ack = ack; cause_clear = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input int idx, input logic e_irq, input logic e_sys,
                          input logic e_core, input logic e_cause, input logic [7:0] e_cnt);
      chk({tag, ".irq"},   idx, {7'd0, irq},           {7'd0, e_irq});
      chk({tag, ".sys"},   idx, {7'd0, sys_reset_req}, {7'd0, e_sys});
      chk({tag, ".core"},  idx, {7'd0, core_reset},    {7'd0, e_core});
      chk({tag, ".cause"}, idx, {7'd0, cause},         {7'd0, e_cause});
      chk({tag, ".count"}, idx, event_count,           e_cnt);
   endtask

   initial begin
      //            rst to  grace   pulse  ack clr  irq sys core cause cnt
      vecs[0]  = '{1'b1,1'b0,16'd0,8'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,8'd0};
      vecs[1]  = '{1'b0,1'b0,16'd2,8'd1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,8'd0};
      vecs[2]  = '{1'b0,1'b1,16'd2,8'd1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'd1};
      vecs[3]  = '{1'b0,1'b1,16'd2,8'd1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'd1};
      vecs[4]  = '{1'b0,1'b1,16'd2,8'd1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'd1};
      vecs[5]  = '{1'b0,1'b1,16'd2,8'd1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1,8'd1};
      vecs[6]  = '{1'b0,1'b1,16'd2,8'd1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1,8'd1};
      vecs[7]  = '{1'b0,1'b1,16'd2,8'd1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,8'd1};
      vecs[8]  = '{1'b0,1'b1,16'd2,8'd1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,8'd1};
      vecs[9]  = '{1'b0,1'b0,16'd2,8'd1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,8'd1};
      vecs[10] = '{1'b0,1'b0,16'd2,8'd1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,8'd1};
      vecs[11] = '{1'b0,1'b1,16'd5,8'd1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'd2};
      vecs[12] = '{1'b0,1'b1,16'd5,8'd1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,8'd2};
      vecs[13] = '{1'b0,1'b1,16'd5,8'd1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,8'd2};
      vecs[14] = '{1'b0,1'b1,16'd5,8'd1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,8'd2};
      vecs[15] = '{1'b0,1'b0,16'd5,8'd1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,8'd2};
      vecs[16] = '{1'b0,1'b1,16'd0,8'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'd3};
      vecs[17] = '{1'b0,1'b1,16'd0,8'd0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1,8'd3};
      vecs[18] = '{1'b0,1'b1,16'd0,8'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,8'd3};
      vecs[19] = '{1'b0,1'b0,16'd0,8'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,8'd3};
      vecs[20] = '{1'b0,1'b1,16'd0,8'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'd4};
      vecs[21] = '{1'b0,1'b1,16'd0,8'd0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,8'd4};
      vecs[22] = '{1'b0,1'b0,16'd0,8'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,8'd4};
      vecs[23] = '{1'b0,1'b1,16'd1,8'd3,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'd5};
      vecs[24] = '{1'b0,1'b1,16'd1,8'd3,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'd5};
      vecs[25] = '{1'b0,1'b1,16'd1,8'd3,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1,8'd5};
      vecs[26] = '{1'b1,1'b1,16'd1,8'd3,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,8'd0};
      vecs[27] = '{1'b0,1'b1,16'd1,8'd3,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'd1};
      vecs[28] = '{1'b1,1'b1,16'd1,8'd3,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,8'd0};

      reset = 1'b1; timeout = 1'b0; grace_cycles = '0; pulse_len = '0;
      irq_ack = 1'b0; cause_clear = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].rst, vecs[i].to, vecs[i].gr, vecs[i].pl, vecs[i].ack, vecs[i].clr);
         chk_all("vec", i, vecs[i].e_irq, vecs[i].e_sys, vecs[i].e_core, vecs[i].e_cause, vecs[i].e_cnt);
      end

      // grace=3, pulse=2: irq for 4 cycles, sys_reset_req for 3, then HOLD
      step(1'b1, 1'b0, 16'd3, 8'd2, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'd3, 8'd2, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         step(1'b0, 1'b1, 16'd3, 8'd2, 1'b0, 1'b0);
         chk_all("warn3", c, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
      end
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 1'b1, 16'd3, 8'd2, 1'b0, 1'b0);
         chk_all("rst3", c, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1);
      end
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 1'b1, 16'd3, 8'd2, 1'b0, 1'b0);
         chk_all("hold3", c, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
      end

      // grace=100, ack five cycles into the warning
      step(1'b1, 1'b0, 16'd100, 8'd4, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'd100, 8'd4, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         step(1'b0, 1'b1, 16'd100, 8'd4, 1'b0, 1'b0);
         chk_all("long", c, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
      end
      step(1'b0, 1'b1, 16'd100, 8'd4, 1'b1, 1'b0);
      chk_all("long_ack", 0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
      for (int c = 0; c < 3; c++) begin
         step(1'b0, c == 0, 16'd100, 8'd4, 1'b0, 1'b0);
         chk_all("long_after", c, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
      end

      // 260 acknowledged events saturate the counter
      step(1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
      for (int e = 1; e <= 260; e++) begin
         step(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
         step(1'b0, 1'b1, 16'd0, 8'd0, 1'b0, 1'b0);
         if (e == 255 || e == 256 || e == 260)
            chk("sat_count", e, event_count, (e >= 255) ? 8'hff : 8'(e));
         step(1'b0, 1'b1, 16'd0, 8'd0, 1'b1, 1'b0);
      end
      step(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1);
      chk("clr_cause", 0, {7'd0, cause}, 8'd0);
      step(1'b0, 1'b1, 16'd0, 8'd0, 1'b0, 1'b1);
      chk("clr_vs_start", 0, {7'd0, cause}, 8'd1);
      chk("sat_final", 0, event_count, 8'hff);
      step(1'b0, 1'b1, 16'd0, 8'd0, 1'b1, 1'b0);
      chk_all("sat_ack", 0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hff);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/watchdog_reset_gen.md
WATCHDOG_RESET_GEN -- requirements
Module: watchdog_reset_gen

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port: timeout  input  1  level timeout from watchdog core; stays high until the core is restarted or reset.
REQ-005 SHALL have port: grace_cycles  input  16  warning window length, sampled on event start.
REQ-006 SHALL have port: pulse_len  input  8  reset-request pulse length, sampled on WARN->RESET.
REQ-007 SHALL have port: irq_ack  input  1  single-cycle firmware acknowledge of warning.
REQ-008 SHALL have port: cause_clear  input  1  single-cycle clear of sticky cause.
REQ-009 SHALL have port: irq  output  1  warning interrupt, level.
REQ-010 SHALL have port: sys_reset_req  output  1  system reset request.
REQ-011 SHALL have port: core_reset  output  1  active-high request to reset the watchdog core.
REQ-012 SHALL have port: cause  output  1  sticky "last reset/warning caused by watchdog".
REQ-013 SHALL have port: event_count  output  8  saturating count of timeout events.

Function
REQ-014 SHALL drive all outputs from registers; no combinational input-to-output path.
REQ-015 SHALL register timeout into timeout_prev; event start = timeout high and timeout_prev low.
REQ-016 SHALL implement FSM states IDLE, WARN, RESET, HOLD.
REQ-017 IDLE: on event start SHALL go to WARN, load counter = grace_cycles, set irq, set cause, increment event_count; irq visible the cycle after timeout is first sampled high.
REQ-018 IDLE: irq_ack SHALL be ignored; a timeout already high with no rising edge SHALL NOT start an event.
REQ-019 WARN: irq_ack SHALL clear irq, pulse core_reset high for exactly one cycle, return to IDLE.
REQ-020 WARN: without ack, counter == 0 SHALL go to RESET, clear irq, load counter = pulse_len; otherwise decrement; WARN lasts grace_cycles+1 cycles (grace_cycles = 0 gives 1 cycle).
REQ-021 WARN: irq_ack in the same cycle as counter == 0 SHALL take the ack path.
REQ-022 RESET: sys_reset_req and core_reset SHALL be high; counter decrements; at counter == 0 go to HOLD; asserted for pulse_len+1 cycles.
REQ-023 HOLD: all requests low; return to IDLE when timeout is sampled low.
REQ-024 event_count SHALL saturate at 8'hff, never wrap.
REQ-025 cause_clear SHALL clear cause; simultaneous event start SHALL leave cause set.
REQ-026 irq_ack and cause_clear SHALL be independent; ack does not clear cause.

Reset
REQ-027 reset SHALL force IDLE, counter = 0, timeout_prev = 0, irq = 0, sys_reset_req = 0, core_reset = 0, cause = 0, event_count = 0.
REQ-028 reset asserted mid-WARN or mid-RESET SHALL abort the event; sys_reset_req low the cycle after reset is sampled.
REQ-029 After reset, timeout already high SHALL start an event (timeout_prev reset to 0).

Structure
REQ-030 State encodings SHALL be module-local constants; counter widths (16, 8) SHALL sit with shared watchdog constants alongside the core.
REQ-031 SHALL use one 16-bit down-counter shared by WARN and RESET (states mutually exclusive); pulse_len zero-extended.
REQ-032 No sub-module; target 150-250 lines.

Verification
REQ-033 grace_cycles=3, timeout rises at cycle 10, no ack -> irq high 11..14, sys_reset_req high from 15 for pulse_len+1 cycles, then HOLD until timeout low.
REQ-034 grace_cycles=100, irq_ack 5 cycles after irq -> irq low next cycle, core_reset one-cycle pulse, sys_reset_req never high, cause=1, event_count=1.
REQ-035 grace_cycles=0, pulse_len=0 -> WARN 1 cycle, sys_reset_req exactly 1 cycle.
REQ-036 irq_ack coincident with counter==0 in WARN -> ack path taken, sys_reset_req stays low.
REQ-037 260 events -> event_count=8'hff; cause_clear coincident with event start -> cause=1.
REQ-038 reset asserted in RESET state -> all outputs 0 next cycle; timeout held high -> new WARN starts next cycle after reset release.
